// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the handshaking multi-cycle MIPS-lite controller.
package mc_ctrl_pkg;

  // FSM state encoding; the value is also exported on the debug state port
  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MA    = 3'd3,
    S_WB    = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_OR = 2'b10, ALU_SLT = 2'b11} alu_op_e;
  typedef enum logic [1:0] {EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_LUI = 2'b10} ext_op_e;
  typedef enum logic [1:0] {NPC_PC4 = 2'b00, NPC_BEQ = 2'b01, NPC_J = 2'b10, NPC_JR = 2'b11} npc_op_e;
  typedef enum logic [1:0] {M2R_ALU = 2'b00, M2R_DM = 2'b01, M2R_PC = 2'b10, M2R_OVF = 2'b11} m2r_sel_e;
  typedef enum logic [1:0] {GPR_RD = 2'b00, GPR_RT = 2'b01, GPR_RA = 2'b10, GPR_R30 = 2'b11} gpr_sel_e;
  typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_TIMEOUT = 2'b01, ERR_ILLEGAL = 2'b10} err_code_e;

  // One-hot instruction class; all-zero means the instruction is not supported
  typedef struct packed {
    logic addu;
    logic subu;
    logic slt;
    logic jr;
    logic ori;
    logic lw;
    logic lb;
    logic sw;
    logic sb;
    logic beq;
    logic lui;
    logic j;
    logic jal;
    logic addi;
    logic addiu;
  } instr_t;

  // Every datapath control the FSM produces in one cycle
  typedef struct packed {
    logic     im_req;
    logic     dm_req;
    logic     pc_wr;
    logic     ir_wr;
    logic     gpr_wr;
    logic     dm_wr;
    logic     byte_op;
    logic     alu_src;
    logic     alu_sign;
    alu_op_e  alu_op;
    ext_op_e  ext_op;
    npc_op_e  npc_op;
    m2r_sel_e m2r_sel;
    gpr_sel_e gpr_sel;
  } ctrl_t;

  function automatic logic is_load(input instr_t i);
    return i.lw | i.lb;
  endfunction

  function automatic logic is_store(input instr_t i);
    return i.sw | i.sb;
  endfunction

  function automatic logic is_imm_alu(input instr_t i);
    return i.ori | i.lui | i.addi | i.addiu;
  endfunction

endpackage

// File: rtl/mc_ctrl_hs_if.sv
// Request/acknowledge bus between the controller and the instruction/data memories.
interface mc_ctrl_hs_if;
  logic im_req;
  logic im_ack;
  logic dm_req;
  logic dm_ack;
  logic dm_wr;
  logic byte_op;

  modport master (output im_req, dm_req, dm_wr, byte_op, input im_ack, dm_ack);
  modport slave  (input im_req, dm_req, dm_wr, byte_op, output im_ack, dm_ack);
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder: one-hot instruction class plus illegal flag.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output instr_t     instr,
  output logic       illegal
);

  // Map the IR fields onto exactly one class bit, or none for unsupported encodings
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    instr = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: instr.addu = 1'b1;
          FN_SUBU: instr.subu = 1'b1;
          FN_SLT:  instr.slt  = 1'b1;
          FN_JR:   instr.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_J:     instr.j     = 1'b1;
      OP_JAL:   instr.jal   = 1'b1;
      OP_BEQ:   instr.beq   = 1'b1;
      OP_ADDI:  instr.addi  = 1'b1;
      OP_ADDIU: instr.addiu = 1'b1;
      OP_ORI:   instr.ori   = 1'b1;
      OP_LUI:   instr.lui   = 1'b1;
      OP_LB:    instr.lb    = 1'b1;
      OP_LW:    instr.lw    = 1'b1;
      OP_SB:    instr.sb    = 1'b1;
      OP_SW:    instr.sw    = 1'b1;
      default:  ;
    endcase
    illegal = (instr == '0);
  end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS-lite control unit with memory handshakes, bus timeout and illegal-instruction trap.
// CNT_W must satisfy 2**CNT_W > TIMEOUT so the wait counter can reach TIMEOUT-1.
module mc_ctrl_hs
  import mc_ctrl_pkg::*;
#(
  parameter bit          IM_HS   = 1'b1,
  parameter bit          DM_HS   = 1'b1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic         zero,
  input  logic         overflow,
  mc_ctrl_hs_if.master mem,
  output logic         pc_wr,
  output logic         ir_wr,
  output logic         gpr_wr,
  output logic         alu_src,
  output logic         alu_sign,
  output logic [1:0]   alu_op,
  output logic [1:0]   ext_op,
  output logic [1:0]   npc_op,
  output logic [1:0]   m2r_sel,
  output logic [1:0]   gpr_sel,
  output logic [2:0]   state,
  output logic [1:0]   err_code
);

  // Counter value seen in the last permitted wait cycle
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  err_code_e        err_q, err_d;

  instr_t instr;
  logic   illegal;
  ctrl_t  ctrl_n;
  ctrl_t  ctrl;
  logic   im_done;
  logic   dm_done;

  mc_ctrl_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .instr   (instr),
    .illegal (illegal)
  );

  // A disabled handshake makes the corresponding memory look single-cycle
  assign im_done = mem.im_ack || !IM_HS;
  assign dm_done = mem.dm_ack || !DM_HS;

  // Next-state, wait counter, sticky flags and per-state control outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ovf_d   = ovf_q;
    err_d   = err_q;
    ctrl_n  = '0;

    case (state_q)
      S_FETCH: begin
        ctrl_n.im_req = 1'b1;
        if (im_done) begin
          ctrl_n.ir_wr  = 1'b1;
          ctrl_n.pc_wr  = 1'b1;
          ctrl_n.npc_op = NPC_PC4;
          state_d       = S_DCD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DCD: begin
        if (is_load(instr) || is_store(instr) || instr.addi || instr.addiu || instr.beq) begin
          ctrl_n.ext_op = EXT_SIGN;
        end else if (instr.lui) begin
          ctrl_n.ext_op = EXT_LUI;
        end
        if (illegal) begin
          state_d = S_ERR;
          err_d   = ERR_ILLEGAL;
        end else if (instr.j) begin
          ctrl_n.pc_wr  = 1'b1;
          ctrl_n.npc_op = NPC_J;
          state_d       = S_FETCH;
        end else if (instr.jr) begin
          ctrl_n.pc_wr  = 1'b1;
          ctrl_n.npc_op = NPC_JR;
          state_d       = S_FETCH;
        end else if (instr.jal) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        ctrl_n.alu_src  = is_imm_alu(instr) | is_load(instr) | is_store(instr);
        ctrl_n.alu_sign = instr.slt | instr.addi;
        // lui passes the shifted immediate through an OR with rs ($0)
        if (instr.subu || instr.beq) begin
          ctrl_n.alu_op = ALU_SUB;
        end else if (instr.ori || instr.lui) begin
          ctrl_n.alu_op = ALU_OR;
        end else if (instr.slt) begin
          ctrl_n.alu_op = ALU_SLT;
        end else begin
          ctrl_n.alu_op = ALU_ADD;
        end
        ovf_d = overflow & instr.addi;
        if (instr.beq) begin
          ctrl_n.pc_wr  = zero;
          ctrl_n.npc_op = NPC_BEQ;
          state_d       = S_FETCH;
        end else if (is_load(instr) || is_store(instr)) begin
          state_d = S_MA;
        end else begin
          state_d = S_WB;
        end
      end

      S_MA: begin
        // dm_wr/byte_op depend only on the IR, so they stay stable for the whole request
        ctrl_n.dm_req  = 1'b1;
        ctrl_n.dm_wr   = is_store(instr);
        ctrl_n.byte_op = instr.lb | instr.sb;
        if (dm_done) begin
          state_d = is_load(instr) ? S_WB : S_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        ctrl_n.gpr_wr = 1'b1;
        state_d       = S_FETCH;
        if (instr.jal) begin
          ctrl_n.gpr_sel = GPR_RA;
          ctrl_n.m2r_sel = M2R_PC;
          ctrl_n.pc_wr   = 1'b1;
          ctrl_n.npc_op  = NPC_J;
        end else if (instr.addi && ovf_q) begin
          // Overflowing addi reports the flag in $30 instead of writing rt
          ctrl_n.gpr_sel = GPR_R30;
          ctrl_n.m2r_sel = M2R_OVF;
        end else if (is_load(instr)) begin
          ctrl_n.gpr_sel = GPR_RT;
          ctrl_n.m2r_sel = M2R_DM;
        end else if (is_imm_alu(instr)) begin
          ctrl_n.gpr_sel = GPR_RT;
          ctrl_n.m2r_sel = M2R_ALU;
        end
      end

      S_ERR: ;

      default: state_d = S_FETCH;
    endcase
  end

  // State register, wait counter and sticky flags with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d input.
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // While reset is held every enable, request and select is forced inactive
  assign ctrl = rst ? '0 : ctrl_n;

  assign mem.im_req  = ctrl.im_req;
  assign mem.dm_req  = ctrl.dm_req;
  assign mem.dm_wr   = ctrl.dm_wr;
  assign mem.byte_op = ctrl.byte_op;
  assign pc_wr       = ctrl.pc_wr;
  assign ir_wr       = ctrl.ir_wr;
  assign gpr_wr      = ctrl.gpr_wr;
  assign alu_src     = ctrl.alu_src;
  assign alu_sign    = ctrl.alu_sign;
  assign alu_op      = ctrl.alu_op;
  assign ext_op      = ctrl.ext_op;
  assign npc_op      = ctrl.npc_op;
  assign m2r_sel     = ctrl.m2r_sel;
  assign gpr_sel     = ctrl.gpr_sel;
  assign state       = state_q;
  assign err_code    = err_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Self-checking bench for mc_ctrl_hs: per-cycle expected traces built from instruction semantics.
module tb_mc_ctrl_hs;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic       pc_wr, ir_wr, gpr_wr, alu_src, alu_sign;
  logic [1:0] alu_op, ext_op, npc_op, m2r_sel, gpr_sel, err_code;
  logic [2:0] state;

  logic       rst_nh;
  logic [5:0] opcode_nh, funct_nh;
  logic       pc_wr_nh, ir_wr_nh, gpr_wr_nh, alu_src_nh, alu_sign_nh;
  logic [1:0] alu_op_nh, ext_op_nh, npc_op_nh, m2r_sel_nh, gpr_sel_nh, err_code_nh;
  logic [2:0] state_nh;

  int tests = 0;
  int fails = 0;

  mc_ctrl_hs_if hs_if ();
  mc_ctrl_hs_if nh_if ();

  always #5 clk = ~clk;

  mc_ctrl_hs #(.IM_HS(1'b1), .DM_HS(1'b1), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .mem(hs_if.master), .pc_wr(pc_wr), .ir_wr(ir_wr), .gpr_wr(gpr_wr), .alu_src(alu_src),
    .alu_sign(alu_sign), .alu_op(alu_op), .ext_op(ext_op), .npc_op(npc_op), .m2r_sel(m2r_sel),
    .gpr_sel(gpr_sel), .state(state), .err_code(err_code)
  );

  mc_ctrl_hs #(.IM_HS(1'b0), .DM_HS(1'b0), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut_nh (
    .clk(clk), .rst(rst_nh), .opcode(opcode_nh), .funct(funct_nh), .zero(1'b0), .overflow(1'b0),
    .mem(nh_if.master), .pc_wr(pc_wr_nh), .ir_wr(ir_wr_nh), .gpr_wr(gpr_wr_nh), .alu_src(alu_src_nh),
    .alu_sign(alu_sign_nh), .alu_op(alu_op_nh), .ext_op(ext_op_nh), .npc_op(npc_op_nh),
    .m2r_sel(m2r_sel_nh), .gpr_sel(gpr_sel_nh), .state(state_nh), .err_code(err_code_nh)
  );

  // Expected control bundle, bit order matches obs_v below
  typedef struct packed {
    logic im_req, dm_req, pc_wr, ir_wr, gpr_wr, dm_wr, byte_op, alu_src, alu_sign;
    logic [1:0] alu_op, ext_op, npc_op, m2r, gsel;
  } outs_t;

  typedef struct {
    logic [2:0] st;
    logic [1:0] err;
    logic       im_ack, dm_ack, zero, ovf;
    outs_t      o;
  } cyc_t;

  typedef enum {K_ILL, K_R, K_JR, K_J, K_JAL, K_IMM, K_LD, K_ST, K_BEQ} kind_e;

  typedef struct {
    kind_e      kind;
    logic [1:0] alu_op, ext_op;
    logic       alu_src, alu_sign, addi, byte_acc;
  } info_t;

  logic [18:0] obs_v;
  assign obs_v = {hs_if.im_req, hs_if.dm_req, pc_wr, ir_wr, gpr_wr, hs_if.dm_wr, hs_if.byte_op,
                  alu_src, alu_sign, alu_op, ext_op, npc_op, m2r_sel, gpr_sel};

  cyc_t       trace[$];
  logic [1:0] err_m;
  string      cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", cur, tag, obs, exp);
    end
  endtask

  // Instruction semantics table: class and EXE/DCD control values
  function automatic info_t classify(input logic [5:0] op, input logic [5:0] fn);
    info_t a;
    a.kind = K_ILL; a.alu_op = 2'd0; a.ext_op = 2'd0;
    a.alu_src = 1'b0; a.alu_sign = 1'b0; a.addi = 1'b0; a.byte_acc = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h21: a.kind = K_R;
        6'h23: begin a.kind = K_R; a.alu_op = 2'd1; end
        6'h2A: begin a.kind = K_R; a.alu_op = 2'd3; a.alu_sign = 1'b1; end
        6'h08: a.kind = K_JR;
        default: ;
      endcase
      6'h02: a.kind = K_J;
      6'h03: a.kind = K_JAL;
      6'h04: begin a.kind = K_BEQ; a.alu_op = 2'd1; a.ext_op = 2'd1; end
      6'h08: begin a.kind = K_IMM; a.alu_src = 1'b1; a.alu_sign = 1'b1; a.ext_op = 2'd1; a.addi = 1'b1; end
      6'h09: begin a.kind = K_IMM; a.alu_src = 1'b1; a.ext_op = 2'd1; end
      6'h0D: begin a.kind = K_IMM; a.alu_src = 1'b1; a.alu_op = 2'd2; end
      6'h0F: begin a.kind = K_IMM; a.alu_src = 1'b1; a.alu_op = 2'd2; a.ext_op = 2'd2; end
      6'h20: begin a.kind = K_LD; a.alu_src = 1'b1; a.ext_op = 2'd1; a.byte_acc = 1'b1; end
      6'h23: begin a.kind = K_LD; a.alu_src = 1'b1; a.ext_op = 2'd1; end
      6'h28: begin a.kind = K_ST; a.alu_src = 1'b1; a.ext_op = 2'd1; a.byte_acc = 1'b1; end
      6'h2B: begin a.kind = K_ST; a.alu_src = 1'b1; a.ext_op = 2'd1; end
      default: ;
    endcase
    return a;
  endfunction

  // Cycle with idle outputs; inputs that must not matter are randomized
  function automatic cyc_t mk(input logic [2:0] st);
    cyc_t c;
    c.st = st; c.err = err_m; c.o = '0;
    c.im_ack = 1'($urandom); c.dm_ack = 1'($urandom);
    c.zero = 1'($urandom); c.ovf = 1'($urandom);
    return c;
  endfunction

  task automatic add_err();
    for (int i = 0; i < 3; i++) trace.push_back(mk(3'd5));
  endtask

  // Build the full expected cycle trace of one instruction
  task automatic build(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input int im_dly, input int dm_dly, input logic z, input logic ov);
    cyc_t c;
    info_t a;
    cur = name;
    a = classify(op, fn);
    opcode = op; funct = fn;
    trace.delete();
    for (int i = 0; i < TIMEOUT; i++) begin
      c = mk(3'd0); c.im_ack = 1'b0; c.o.im_req = 1'b1;
      if (i == im_dly) begin
        c.im_ack = 1'b1; c.o.ir_wr = 1'b1; c.o.pc_wr = 1'b1;
        trace.push_back(c);
        break;
      end
      trace.push_back(c);
    end
    if (im_dly >= TIMEOUT) begin err_m = 2'd1; add_err(); return; end
    c = mk(3'd1); c.o.ext_op = a.ext_op;
    case (a.kind)
      K_ILL: begin trace.push_back(c); err_m = 2'd2; add_err(); return; end
      K_J:   begin c.o.pc_wr = 1'b1; c.o.npc_op = 2'd2; trace.push_back(c); return; end
      K_JR:  begin c.o.pc_wr = 1'b1; c.o.npc_op = 2'd3; trace.push_back(c); return; end
      default: trace.push_back(c);
    endcase
    if (a.kind != K_JAL) begin
      c = mk(3'd2); c.zero = z; c.ovf = ov;
      c.o.alu_src = a.alu_src; c.o.alu_op = a.alu_op; c.o.alu_sign = a.alu_sign;
      if (a.kind == K_BEQ) begin c.o.pc_wr = z; c.o.npc_op = 2'd1; end
      trace.push_back(c);
      if (a.kind == K_BEQ) return;
    end
    if (a.kind == K_LD || a.kind == K_ST) begin
      for (int i = 0; i < TIMEOUT; i++) begin
        c = mk(3'd3); c.dm_ack = (i == dm_dly);
        c.o.dm_req = 1'b1; c.o.dm_wr = (a.kind == K_ST); c.o.byte_op = a.byte_acc;
        trace.push_back(c);
        if (i == dm_dly) break;
      end
      if (dm_dly >= TIMEOUT) begin err_m = 2'd1; add_err(); return; end
      if (a.kind == K_ST) return;
    end
    c = mk(3'd4); c.o.gpr_wr = 1'b1;
    case (a.kind)
      K_JAL: begin c.o.gsel = 2'd2; c.o.m2r = 2'd2; c.o.pc_wr = 1'b1; c.o.npc_op = 2'd2; end
      K_LD:  begin c.o.gsel = 2'd1; c.o.m2r = 2'd1; end
      K_IMM: begin
        if (a.addi && ov) begin c.o.gsel = 2'd3; c.o.m2r = 2'd3; end
        else c.o.gsel = 2'd1;
      end
      default: ;
    endcase
    trace.push_back(c);
  endtask

  // Replay the trace (up to max_cyc cycles, 0 = all) checking every cycle
  task automatic run(input int max_cyc);
    cyc_t c;
    int   k = 0;
    while (trace.size() > 0 && (max_cyc == 0 || k < max_cyc)) begin
      c = trace.pop_front();
      hs_if.im_ack = c.im_ack; hs_if.dm_ack = c.dm_ack;
      zero = c.zero; overflow = c.ovf;
      #1;
      check($sformatf("c%0d.state", k), 32'(state), 32'(c.st));
      check($sformatf("c%0d.outs", k), 32'(obs_v), 32'(c.o));
      check($sformatf("c%0d.err", k), 32'(err_code), 32'(c.err));
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; hs_if.im_ack = 1'b0; hs_if.dm_ack = 1'b0;
    #1;
    check("rst.outs", 32'(obs_v), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.state", 32'(state), 32'd0);
    check("rst.err", 32'(err_code), 32'd0);
    check("rst.dm_req", 32'(hs_if.dm_req), 32'd0);
    err_m = 2'd0;
    trace.delete();
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int im_dly, input int dm_dly, input logic z, input logic ov);
    build(name, op, fn, im_dly, dm_dly, z, ov);
    run(0);
    if (err_m != 2'd0) do_reset();
  endtask

  logic [5:0] legal_op [15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h23, 6'h20, 6'h2B,
                                6'h28, 6'h04, 6'h0F, 6'h02, 6'h03, 6'h08, 6'h09};
  logic [5:0] legal_fn [15] = '{6'h21, 6'h23, 6'h2A, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = 6'h00; funct = 6'h21; zero = 1'b0; overflow = 1'b0;
    hs_if.im_ack = 1'b0; hs_if.dm_ack = 1'b0;
    rst_nh = 1'b1; opcode_nh = 6'h00; funct_nh = 6'h00;
    nh_if.im_ack = 1'b0; nh_if.dm_ack = 1'b0;
    err_m = 2'd0; cur = "reset";
    @(negedge clk);
    do_reset();

    // Directed instruction mix
    run_instr("addu",  6'h00, 6'h21, 3, 0, 1'b0, 1'b0);
    run_instr("lw",    6'h23, 6'h00, 1, 2, 1'b0, 1'b0);
    run_instr("sw",    6'h2B, 6'h00, 0, 1, 1'b0, 1'b0);
    run_instr("lb",    6'h20, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("sb",    6'h28, 6'h00, 2, 3, 1'b0, 1'b0);
    run_instr("beq1",  6'h04, 6'h00, 0, 0, 1'b1, 1'b0);
    run_instr("beq0",  6'h04, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("jal",   6'h03, 6'h00, 1, 0, 1'b0, 1'b0);
    run_instr("addiv", 6'h08, 6'h00, 0, 0, 1'b0, 1'b1);
    run_instr("addi",  6'h08, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("addiu", 6'h09, 6'h00, 0, 0, 1'b0, 1'b1);
    run_instr("j",     6'h02, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("jr",    6'h00, 6'h08, 0, 0, 1'b0, 1'b0);
    run_instr("ori",   6'h0D, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("lui",   6'h0F, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("subu",  6'h00, 6'h23, 0, 0, 1'b0, 1'b0);
    run_instr("slt",   6'h00, 6'h2A, 0, 0, 1'b0, 1'b0);

    // Boundaries: ack on the last allowed cycle, timeouts, illegal encodings
    run_instr("im_edge", 6'h00, 6'h21, TIMEOUT - 1, 0, 1'b0, 1'b0);
    run_instr("dm_edge", 6'h23, 6'h00, 0, TIMEOUT - 1, 1'b0, 1'b0);
    run_instr("im_to",   6'h00, 6'h21, 100, 0, 1'b0, 1'b0);
    run_instr("dm_to",   6'h2B, 6'h00, 0, 100, 1'b0, 1'b0);
    run_instr("ill_op",  6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("ill_fn",  6'h00, 6'h00, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of a data wait drops the request
    build("rst_ma", 6'h23, 6'h00, 0, 50, 1'b0, 1'b0);
    run(5);
    do_reset();

    // Random legal instructions with random latencies and flags
    for (int n = 0; n < 40; n++) begin
      int idx;
      idx = int'($urandom_range(14, 0));
      run_instr($sformatf("rnd%0d", n), legal_op[idx], legal_fn[idx],
                int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
                1'($urandom), 1'($urandom));
    end

    // Handshakes disabled: lw completes in exactly five cycles
    cur = "nohs_lw";
    opcode_nh = 6'h23; funct_nh = 6'h00;
    rst_nh = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("c%0d.state", i), 32'(state_nh), 32'(i));
      if (i == 0) check("fetch.ir_wr", 32'(ir_wr_nh), 32'd1);
      if (i == 3) check("ma.dm_req", 32'(nh_if.dm_req), 32'd1);
      if (i == 4) check("wb.sel", 32'({gpr_wr_nh, gpr_sel_nh, m2r_sel_nh}), 32'b10101);
      @(negedge clk);
    end
    #1;
    check("done.state", 32'(state_nh), 32'd0);
    rst_nh = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
